// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Forwarding-select codes, mul/div tracker state encoding and the select-priority helper.
package hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // MEM always wins over WB because it holds the younger value.
    function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
        if (mem_hit) begin
            return FWD_MEM;
        end else if (wb_hit) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-register observation bus and hazard-control outputs of hazard_ctrl.
// master drives the pipeline view; slave is the hazard controller.
interface hazard_ctrl_if #(
    parameter int AW = 5
);
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic          id_branch;
    logic          id_hilo;
    logic [AW-1:0] ex_rs;
    logic [AW-1:0] ex_rt;
    logic          ex_regwrite;
    logic          ex_mem2reg;
    logic [AW-1:0] ex_rd;
    logic          ex_md_start;
    logic          mem_regwrite;
    logic          mem_mem2reg;
    logic [AW-1:0] mem_rd;
    logic          wb_regwrite;
    logic [AW-1:0] wb_rd;

    logic          stall_if;
    logic          stall_id;
    logic          flush_ex;
    logic [1:0]    fwd_id_a;
    logic [1:0]    fwd_id_b;
    logic [1:0]    fwd_ex_a;
    logic [1:0]    fwd_ex_b;
    logic          md_busy;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_hilo,
        output ex_rs, ex_rt, ex_regwrite, ex_mem2reg, ex_rd, ex_md_start,
        output mem_regwrite, mem_mem2reg, mem_rd, wb_regwrite, wb_rd,
        input  stall_if, stall_id, flush_ex,
        input  fwd_id_a, fwd_id_b, fwd_ex_a, fwd_ex_b, md_busy
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_hilo,
        input  ex_rs, ex_rt, ex_regwrite, ex_mem2reg, ex_rd, ex_md_start,
        input  mem_regwrite, mem_mem2reg, mem_rd, wb_regwrite, wb_rd,
        output stall_if, stall_id, flush_ex,
        output fwd_id_a, fwd_id_b, fwd_ex_a, fwd_ex_b, md_busy
    );

endinterface

// File: rtl/hazard_ctrl_md_tracker.sv
// Multi-cycle mul/div occupancy tracker: md_busy_o is high for exactly MD_CYCLES
// cycles starting on the edge that samples md_start_i.
//   state   | meaning
//   MD_IDLE | no mul/div in flight, HI/LO readable
//   MD_BUSY | result pending, cnt_q cycles remain after this one
module md_tracker
    import hazard_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start_i,
    output logic md_busy_o
);

    localparam int              CW       = $clog2(MD_CYCLES);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(MD_CYCLES - 1);

    md_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // A start while busy is dropped; the ID interlock keeps it from happening.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (md_start_i) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign md_busy_o = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: stall/flush, forwarding selects and HI/LO interlock.
// Define HAZARD_FWD_EN for the forwarding build; otherwise interlock-only with fwd_* tied to REG.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int AW        = 5,
    parameter int MD_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    hazard_ctrl_if.slave bus
);

    logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic          rs_ex, rt_ex, rs_mem, rt_mem, rs_wb, rt_wb;
    logic          hit_ex, hit_mem;
    logic          haz;
    logic          md_busy;
    logic [1:0]    fwd_id_a, fwd_id_b, fwd_ex_a, fwd_ex_b;

    assign id_rs  = bus.id_rs;
    assign id_rt  = bus.id_rt;
    assign ex_rs  = bus.ex_rs;
    assign ex_rt  = bus.ex_rt;
    assign ex_rd  = bus.ex_rd;
    assign mem_rd = bus.mem_rd;
    assign wb_rd  = bus.wb_rd;

    // Address-only matches of the ID sources; writer qualification happens per rule.
    assign rs_ex  = bus.id_use_rs && (ex_rd  != '0) && (id_rs == ex_rd);
    assign rt_ex  = bus.id_use_rt && (ex_rd  != '0) && (id_rt == ex_rd);
    assign rs_mem = bus.id_use_rs && (mem_rd != '0) && (id_rs == mem_rd);
    assign rt_mem = bus.id_use_rt && (mem_rd != '0) && (id_rt == mem_rd);
    assign rs_wb  = bus.id_use_rs && (wb_rd  != '0) && (id_rs == wb_rd);
    assign rt_wb  = bus.id_use_rt && (wb_rd  != '0) && (id_rt == wb_rd);

    assign hit_ex  = rs_ex  || rt_ex;
    assign hit_mem = rs_mem || rt_mem;

`ifdef HAZARD_FWD_EN
    logic load_use, br_alu, br_load;
    logic mem_alu_wr;
    logic exa_mem, exb_mem, exa_wb, exb_wb;

    assign load_use = bus.ex_mem2reg && hit_ex;
    assign br_alu   = bus.id_branch && bus.ex_regwrite && hit_ex;
    assign br_load  = bus.id_branch && bus.mem_mem2reg && hit_mem;
    assign haz      = load_use || br_alu || br_load;

    // A load in MEM has no data yet, so the branch comparator may not take it from there.
    assign mem_alu_wr = bus.mem_regwrite && !bus.mem_mem2reg;
    assign fwd_id_a   = fwd_sel(mem_alu_wr && rs_mem, bus.wb_regwrite && rs_wb);
    assign fwd_id_b   = fwd_sel(mem_alu_wr && rt_mem, bus.wb_regwrite && rt_wb);

    assign exa_mem  = bus.mem_regwrite && (mem_rd != '0) && (ex_rs == mem_rd);
    assign exb_mem  = bus.mem_regwrite && (mem_rd != '0) && (ex_rt == mem_rd);
    assign exa_wb   = bus.wb_regwrite  && (wb_rd  != '0) && (ex_rs == wb_rd);
    assign exb_wb   = bus.wb_regwrite  && (wb_rd  != '0) && (ex_rt == wb_rd);
    assign fwd_ex_a = fwd_sel(exa_mem, exa_wb);
    assign fwd_ex_b = fwd_sel(exb_mem, exb_wb);
`else
    logic unused_fwd;

    // Write-first register file covers WB, so only EX and MEM writers interlock.
    assign haz = ((bus.ex_regwrite  || bus.ex_mem2reg)  && hit_ex) ||
                 ((bus.mem_regwrite || bus.mem_mem2reg) && hit_mem);

    assign fwd_id_a = FWD_REG;
    assign fwd_id_b = FWD_REG;
    assign fwd_ex_a = FWD_REG;
    assign fwd_ex_b = FWD_REG;

    assign unused_fwd = ^{rs_wb, rt_wb, bus.wb_regwrite, bus.id_branch, ex_rs, ex_rt};
`endif

    md_tracker #(
        .MD_CYCLES (MD_CYCLES)
    ) u_md_tracker (
        .clk        (clk),
        .rst        (rst),
        .md_start_i (bus.ex_md_start),
        .md_busy_o  (md_busy)
    );

    assign bus.stall_if = haz || (md_busy && bus.id_hilo);
    assign bus.stall_id = bus.stall_if;
    assign bus.flush_ex = bus.stall_if;
    assign bus.fwd_id_a = fwd_id_a;
    assign bus.fwd_id_b = fwd_id_b;
    assign bus.fwd_ex_a = fwd_ex_a;
    assign bus.fwd_ex_b = fwd_ex_b;
    assign bus.md_busy  = md_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl with MD_CYCLES=4; expectations follow
// the forwarding or interlock-only build depending on HAZARD_FWD_EN.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int MDC = 4;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.AW(5)) bus ();

    hazard_ctrl #(.AW(5), .MD_CYCLES(MDC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    string       tag_q[$];
    logic [11:0] exp_q[$];

    function automatic logic [1:0] fx(input logic [1:0] v);
        return FWD ? v : FWD_REG;
    endfunction

    task automatic push(input string tag, input logic stall, input logic [1:0] fia,
                        input logic [1:0] fib, input logic [1:0] fea, input logic [1:0] feb,
                        input logic busy);
        tag_q.push_back(tag);
        exp_q.push_back({stall, stall, stall, fia, fib, fea, feb, busy});
    endtask

    task automatic check();
        string       tag;
        logic [11:0] e, obs;
        while (tag_q.size() > 0) begin
            tag = tag_q.pop_front();
            e   = exp_q.pop_front();
            obs = {bus.stall_if, bus.stall_id, bus.flush_ex, bus.fwd_id_a, bus.fwd_id_b,
                   bus.fwd_ex_a, bus.fwd_ex_b, bus.md_busy};
            vectors++;
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed %b expected %b (sif,sid,flush,fida,fidb,fexa,fexb,busy)",
                       tag, obs, e);
            end
        end
    endtask

    task automatic clear_in();
        bus.id_rs = '0;        bus.id_rt = '0;
        bus.id_use_rs = 1'b0;  bus.id_use_rt = 1'b0;
        bus.id_branch = 1'b0;  bus.id_hilo = 1'b0;
        bus.ex_rs = '0;        bus.ex_rt = '0;
        bus.ex_regwrite = 1'b0; bus.ex_mem2reg = 1'b0;
        bus.ex_rd = '0;        bus.ex_md_start = 1'b0;
        bus.mem_regwrite = 1'b0; bus.mem_mem2reg = 1'b0; bus.mem_rd = '0;
        bus.wb_regwrite = 1'b0;  bus.wb_rd = '0;
    endtask

    task automatic step_begin();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic step_end();
        @(negedge clk);
        check();
    endtask

    // A second mul/div start while one is in flight must never be issued.
    always @(posedge clk) begin
        if (rst === 1'b0 && bus.ex_md_start === 1'b1 && bus.md_busy === 1'b1) begin
            miscompares++;
            $display("FAIL md_start_while_busy: observed start=1 busy=1 required busy=0");
        end
    end

    initial begin
        rst = 1'b1;
        clear_in();
        #12;
        push("reset", 1'b0, FWD_REG, FWD_REG, FWD_REG, FWD_REG, 1'b0);
        check();
        @(negedge clk);
        rst = 1'b0;

        step_begin();
        bus.ex_mem2reg = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd8;
        bus.id_rs = 5'd8; bus.id_use_rs = 1'b1;
        push("load_use", 1'b1, FWD_REG, FWD_REG, FWD_REG, FWD_REG, 1'b0);
        step_end();

        step_begin();
        bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd8;
        bus.ex_rs = 5'd8; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd10;
        bus.id_rs = 5'd10; bus.id_use_rs = 1'b1;
        push("load_then_wb_fwd", !FWD, FWD_REG, FWD_REG, fx(FWD_WB), FWD_REG, 1'b0);
        step_end();

        step_begin();
        bus.id_branch = 1'b1; bus.id_rs = 5'd9; bus.id_use_rs = 1'b1;
        bus.mem_regwrite = 1'b1; bus.mem_mem2reg = 1'b1; bus.mem_rd = 5'd9;
        push("branch_after_load", 1'b1, FWD_REG, FWD_REG, FWD_REG, FWD_REG, 1'b0);
        step_end();

        step_begin();
        bus.id_branch = 1'b1; bus.id_rs = 5'd9; bus.id_use_rs = 1'b1;
        bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd9;
        push("branch_alu_in_mem", !FWD, fx(FWD_MEM), FWD_REG, FWD_REG, FWD_REG, 1'b0);
        step_end();

        step_begin();
        bus.id_branch = 1'b1; bus.id_rt = 5'd9; bus.id_use_rt = 1'b1;
        bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd9;
        push("branch_alu_in_ex", 1'b1, FWD_REG, FWD_REG, FWD_REG, FWD_REG, 1'b0);
        step_end();

        step_begin();
        bus.ex_rd = 5'd0; bus.ex_mem2reg = 1'b1; bus.ex_regwrite = 1'b1;
        bus.id_rs = 5'd0; bus.id_use_rs = 1'b1; bus.id_branch = 1'b1;
        bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd0; bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd0;
        push("zero_reg", 1'b0, FWD_REG, FWD_REG, FWD_REG, FWD_REG, 1'b0);
        step_end();

        step_begin();
        bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd4;
        bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd4; bus.ex_rs = 5'd4;
        push("mem_over_wb", 1'b0, FWD_REG, FWD_REG, fx(FWD_MEM), FWD_REG, 1'b0);
        step_end();

        step_begin();
        bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd5; bus.ex_rs = 5'd5;
        bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd6; bus.ex_rt = 5'd6;
        bus.id_rs = 5'd5; bus.id_rt = 5'd6; bus.id_use_rt = 1'b1;
        push("split_fwd_use_gate", 1'b0, FWD_REG, fx(FWD_WB), fx(FWD_MEM), fx(FWD_WB), 1'b0);
        step_end();

        step_begin();
        bus.mem_regwrite = 1'b1; bus.mem_mem2reg = 1'b1; bus.mem_rd = 5'd3;
        bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd3;
        bus.id_rs = 5'd3; bus.id_use_rs = 1'b1;
        push("id_skip_mem_load", !FWD, fx(FWD_WB), FWD_REG, FWD_REG, FWD_REG, 1'b0);
        step_end();

        step_begin();
        bus.ex_md_start = 1'b1;
        push("md_start", 1'b0, FWD_REG, FWD_REG, FWD_REG, FWD_REG, 1'b0);
        step_end();

        for (int i = 0; i < MDC; i++) begin
            step_begin();
            bus.id_hilo = 1'b1;
            if (i == 1) begin
                bus.ex_mem2reg = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd8;
                bus.id_rs = 5'd8; bus.id_use_rs = 1'b1;
            end
            push($sformatf("md_busy_cyc%0d", i), 1'b1, FWD_REG, FWD_REG, FWD_REG, FWD_REG, 1'b1);
            step_end();
        end

        step_begin();
        bus.id_hilo = 1'b1;
        push("md_done_mfhi_go", 1'b0, FWD_REG, FWD_REG, FWD_REG, FWD_REG, 1'b0);
        step_end();

        step_begin();
        bus.ex_md_start = 1'b1;
        push("md_start2", 1'b0, FWD_REG, FWD_REG, FWD_REG, FWD_REG, 1'b0);
        step_end();

        for (int i = 0; i < 2; i++) begin
            step_begin();
            bus.id_hilo = 1'b1;
            push($sformatf("md2_busy_cyc%0d", i), 1'b1, FWD_REG, FWD_REG, FWD_REG, FWD_REG, 1'b1);
            step_end();
        end

        rst = 1'b1;
        #1;
        push("rst_abort", 1'b0, FWD_REG, FWD_REG, FWD_REG, FWD_REG, 1'b0);
        check();
        #1;
        rst = 1'b0;

        step_begin();
        bus.id_hilo = 1'b1;
        push("post_rst_mfhi", 1'b0, FWD_REG, FWD_REG, FWD_REG, FWD_REG, 1'b0);
        step_end();

        step_begin();
        bus.ex_md_start = 1'b1;
        push("md_start3", 1'b0, FWD_REG, FWD_REG, FWD_REG, FWD_REG, 1'b0);
        step_end();

        step_begin();
        bus.id_hilo = 1'b1;
        push("md3_busy", 1'b1, FWD_REG, FWD_REG, FWD_REG, FWD_REG, 1'b1);
        step_end();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
